// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: decides advance/hold/bubble for the PC and the four
// pipeline latches, tracks the halted state and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dmemREN,
  input  logic             exmem_dmemWEN,
  input  logic             idex_dmemREN,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state, next_state;

  logic mem_busy;
  logic load_use;
  logic freeze;
  logic flush_evt;
  logic stall_evt;

  assign mem_busy = (exmem_dmemREN | exmem_dmemWEN) & ~dhit;
  assign load_use = idex_dmemREN & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  assign freeze   = mem_busy | ~ihit;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    next_state  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_evt   = 1'b0;

    if (state == HALTED || halt_wb) begin
      next_state = HALTED;
    end else if (nRST && !freeze) begin
      if (branch_taken) begin
        // MEM instruction retires; the three younger wrong-path instructions become nops.
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

  assign stall_evt = (state == RUN) & ~halt_wb & ~pc_en;
  assign halted    = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      state <= next_state;
      if (stall_evt && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level
// reference model; a CNT_W=4 copy shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, exmem_dmemREN, exmem_dmemWEN, idex_dmemREN;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       branch_taken, halt_wb;

  logic       pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
  logic       ifid_flush_a, idex_flush_a, exmem_flush_a, halted_a;
  logic [15:0] stall_a, flush_a;
  logic       pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
  logic       ifid_flush_b, idex_flush_b, exmem_flush_b, halted_b;
  logic [3:0] stall_b, flush_b;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit m_halted;
  int m_stall, m_flush;

  // Expected output vector per decision class:
  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush}
  localparam int K_HALT = 1, K_FREEZE = 2, K_BRANCH = 3, K_LOADUSE = 4, K_NORMAL = 5;
  logic [7:0] kind_vec [6] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'b0011_1010, 8'hF8};

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dmemREN(exmem_dmemREN), .exmem_dmemWEN(exmem_dmemWEN),
    .idex_dmemREN(idex_dmemREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .halt_wb(halt_wb),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .exmem_en(exmem_en_a),
    .memwb_en(memwb_en_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
    .exmem_flush(exmem_flush_a), .halted(halted_a),
    .stall_count(stall_a), .flush_count(flush_a)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dmemREN(exmem_dmemREN), .exmem_dmemWEN(exmem_dmemWEN),
    .idex_dmemREN(idex_dmemREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .halt_wb(halt_wb),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
    .memwb_en(memwb_en_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
    .exmem_flush(exmem_flush_b), .halted(halted_b),
    .stall_count(stall_b), .flush_count(flush_b)
  );

  wire [7:0] out_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a,
                      ifid_flush_a, idex_flush_a, exmem_flush_a};
  wire [7:0] out_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b,
                      ifid_flush_b, idex_flush_b, exmem_flush_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int classify();
    if (m_halted || halt_wb) return K_HALT;
    if (((exmem_dmemREN || exmem_dmemWEN) && !dhit) || !ihit) return K_FREEZE;
    if (branch_taken) return K_BRANCH;
    if (idex_dmemREN && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt))
      return K_LOADUSE;
    return K_NORMAL;
  endfunction

  function automatic int sat_inc(int v, int lim);
    return (v < lim) ? v + 1 : v;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".halted"}, {31'd0, halted_a}, {31'd0, m_halted});
    check({tag, ".halted4"}, {31'd0, halted_b}, {31'd0, m_halted});
    check({tag, ".stall16"}, {16'd0, stall_a}, (m_stall > 65535) ? 65535 : m_stall);
    check({tag, ".flush16"}, {16'd0, flush_a}, (m_flush > 65535) ? 65535 : m_flush);
    check({tag, ".stall4"}, {28'd0, stall_b}, (m_stall > 15) ? 15 : m_stall);
    check({tag, ".flush4"}, {28'd0, flush_b}, (m_flush > 15) ? 15 : m_flush);
  endtask

  // Apply one cycle of inputs, check combinational outputs, clock, then check state.
  task automatic step(input string tag, input logic ih, dh, mr, mw, ir,
                      input logic [4:0] rt, rs, rtt, input logic br, hw);
    int k;
    ihit = ih; dhit = dh; exmem_dmemREN = mr; exmem_dmemWEN = mw; idex_dmemREN = ir;
    idex_rt = rt; ifid_rs = rs; ifid_rt = rtt; branch_taken = br; halt_wb = hw;
    #1;
    k = classify();
    check({tag, ".out16"}, {24'd0, out_a}, {24'd0, kind_vec[k]});
    check({tag, ".out4"}, {24'd0, out_b}, {24'd0, kind_vec[k]});
    @(posedge CLK);
    if (!m_halted) begin
      if (hw) m_halted = 1'b1;
      else begin
        if (!kind_vec[k][7]) m_stall = sat_inc(m_stall, 1 << 20);
        if (k == K_BRANCH) m_flush = sat_inc(m_flush, 1 << 20);
      end
    end
    #1;
    check_state(tag);
  endtask

  // Reset pulse mid-cycle: everything must clear before the next clock edge.
  task automatic reset_pulse(input string tag);
    nRST = 1'b0;
    #2;
    m_halted = 1'b0; m_stall = 0; m_flush = 0;
    check({tag, ".rst_out16"}, {24'd0, out_a}, 32'd0);
    check({tag, ".rst_out4"}, {24'd0, out_b}, 32'd0);
    check_state({tag, ".rst"});
    nRST = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; exmem_dmemREN = 1'b0; exmem_dmemWEN = 1'b0;
    idex_dmemREN = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    branch_taken = 1'b0; halt_wb = 1'b0;
    m_halted = 1'b0; m_stall = 0; m_flush = 0;
    #1;
    check("reset.out16", {24'd0, out_a}, 32'd0);
    check_state("reset");
    @(posedge CLK); #1;
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) step("normal", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("normal.stall", {16'd0, stall_a}, 32'd0);

    step("loaduse", 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 0);
    check("loaduse.stall", {16'd0, stall_a}, 32'd1);
    step("loaduse_rt", 1, 0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 0, 0);
    step("loaduse_r0", 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    check("loaduse_r0.stall", {16'd0, stall_a}, 32'd2);

    for (int i = 0; i < 3; i++) step("memwait", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("memdone", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("memwait.stall", {16'd0, stall_a}, 32'd5);

    step("br_lu", 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    check("br_lu.flush", {16'd0, flush_a}, 32'd1);
    step("br_frozen", 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step("br_frozen", 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step("br_release", 1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    check("br_release.flush", {16'd0, flush_a}, 32'd2);

    step("halt", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++)
      step("halted", logic'(i[0]), 1, 0, 0, 1, 5'd4, 5'd4, 0, logic'(~i[0]), 0);
    @(posedge CLK); #3;
    reset_pulse("halt_rst");

    for (int i = 0; i < 20; i++) step("sat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat.stall4", {28'd0, stall_b}, 32'd15);
    for (int i = 0; i < 20; i++) step("satflush", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    check("sat.flush4", {28'd0, flush_b}, 32'd15);
    @(posedge CLK); #3;
    reset_pulse("sat_rst");

    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      step("rand",
           logic'($urandom_range(0, 5) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0),
           logic'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 60) == 0));
      if (m_halted) halt_cycles++;
      if (halt_cycles > 4) begin
        halt_cycles = 0;
        reset_pulse("rand_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
